// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin arbiter feeding one UART TX path, plus the enable_16 baud tick generator.
module uart_tx_scheduler #(
  parameter int NREQ = 4,
  parameter int DIV_W = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [DIV_W-1:0]  divisor,
  input  logic              hold,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   gnt,
  output logic              enable_16,
  output logic [7:0]        tx_data,
  output logic              tx_wr,
  input  logic              tx_done,
  output logic              busy
);
  localparam int PW = $clog2(NREQ);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, state_n;
  logic [DIV_W-1:0] cnt;
  logic [PW-1:0] last, last_n, win, j;
  logic found, grant;
  logic [7:0] win_data, data_n;
  logic [NREQ-1:0] gnt_n;
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      cnt <= '0;
      enable_16 <= 1'b0;
    end else begin
      enable_16 <= (cnt == '0);
      cnt <= (cnt == '0) ? divisor : cnt - DIV_W'(1);
    end
  // search starts just after the last winner and wraps modulo NREQ
  always_comb begin
    found = 1'b0;
    win = last;
    win_data = 8'h00;
    j = '0;
    for (int i = 1; i <= NREQ; i++) begin
      j = PW'((int'(last) + i) % NREQ);
      if (!found && req[j]) begin
        found = 1'b1;
        win = j;
        win_data = req_data[{j, 3'b000} +: 8];
      end
    end
  end
  always_comb begin
    grant = (state == IDLE) && !hold && found;
    state_n = grant ? WAIT : (state == WAIT && tx_done) ? IDLE : state;
    last_n = grant ? win : last;
    data_n = grant ? win_data : tx_data;
    gnt_n = grant ? NREQ'(1) << win : '0;
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state <= IDLE;
      last <= PW'(NREQ - 1);
      tx_data <= 8'h00;
      tx_wr <= 1'b0;
      gnt <= '0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      last <= last_n;
      tx_data <= data_n;
      tx_wr <= grant;
      gnt <= gnt_n;
      busy <= (state_n == WAIT);
    end
endmodule
